// File: rtl/pipe_pkg.sv
// Shared decode constants, cause/state encodings and instruction decode helper
// for the pipeline stall sequencer.
package pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  // Mult/div functs are 0110xx: compare only the bits selected by FN_MD_CARE
  localparam logic [5:0] FN_MD_MASK = 6'b011000;
  localparam logic [5:0] FN_MD_CARE = 6'b111100;

  localparam int unsigned MD_CNT_W = 6;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_LOAD = 2'd1,
    CAUSE_LINK = 2'd2,
    CAUSE_MD   = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_LOAD = 2'd1,
    S_LINK = 2'd2,
    S_MD   = 2'd3
  } state_e;

  typedef struct packed {
    logic link;
    logic mdOp;
    logic hiloRd;
  } decode_t;

  function automatic decode_t decodeInstr(logic [5:0] opcode, logic [5:0] funct);
    decode_t d;
    d.link   = (opcode == OP_JAL) || (opcode == OP_SPECIAL && funct == FN_JALR);
    d.mdOp   = (opcode == OP_SPECIAL) && ((funct & FN_MD_CARE) == FN_MD_MASK);
    d.hiloRd = (opcode == OP_SPECIAL) && (funct == FN_MFHI || funct == FN_MFLO);
    return d;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// ID-stage hazard inputs and stall/launch/debug outputs of the stall sequencer.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      id_instr;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       ex_rt;
  logic             ex_is_load;
  logic             ex_reg_write;
  logic             mem_reg_write;
  logic             wb_reg_write;
  logic             perf_clear;
  logic             pc_enable;
  logic             if_enable;
  logic             control_enable;
  logic             md_go;
  logic             md_busy;
  logic [1:0]       stall_cause;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_instr, id_rs, id_rt, ex_rt, ex_is_load,
           ex_reg_write, mem_reg_write, wb_reg_write, perf_clear,
    input  pc_enable, if_enable, control_enable, md_go, md_busy,
           stall_cause, stall_count
  );

  modport slave (
    input  id_instr, id_rs, id_rt, ex_rt, ex_is_load,
           ex_reg_write, mem_reg_write, wb_reg_write, perf_clear,
    output pc_enable, if_enable, control_enable, md_go, md_busy,
           stall_cause, stall_count
  );
endinterface

// File: rtl/muldiv_tracker.sv
// Launches the multi-cycle mult/div unit and counts down its busy window.
module muldiv_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic mdOp,
  input  logic stall,
  output logic mdGo,
  output logic mdBusy
);

  logic [MD_CNT_W-1:0] mdCnt;

  // A stalled op (for any reason) is held in ID and retried, so never launch it
  assign mdGo   = mdOp & ~stall & ~reset;
  assign mdBusy = (mdCnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdCnt <= '0;
    end else if (mdGo) begin
      mdCnt <= MD_CNT_W'(MD_CYCLES);
    end else if (mdBusy) begin
      mdCnt <= mdCnt - MD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central ID-stage stall sequencer: load-use, link-write and mult/div hazards,
// registered stall cause and saturating stall-cycle counter.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 32
) (
  input logic             clk,
  input logic             reset,
  pipe_stall_ctrl_if.slave bus
);

  decode_t          dec;
  logic             loadUse;
  logic             linkWait;
  logic             mdWait;
  logic             stall;
  logic             mdGo;
  logic             mdBusy;
  state_e           state;
  state_e           stateNext;
  cause_e           stallCause;
  logic [CNT_W-1:0] stallCount;
  logic             unusedInstr;

  assign dec         = decodeInstr(bus.id_instr[31:26], bus.id_instr[5:0]);
  assign unusedInstr = ^bus.id_instr[25:6];

  assign loadUse  = bus.ex_is_load && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
  assign linkWait = dec.link && (bus.ex_reg_write || bus.mem_reg_write || bus.wb_reg_write);
  assign mdWait   = (dec.mdOp || dec.hiloRd) && mdBusy;
  // Pipeline must run freely while reset is held
  assign stall    = ~reset & (loadUse | linkWait | mdWait);

  assign bus.pc_enable      = ~stall;
  assign bus.if_enable      = ~stall;
  assign bus.control_enable = ~stall;
  assign bus.md_go          = mdGo;
  assign bus.md_busy        = mdBusy;
  assign bus.stall_cause    = stallCause;
  assign bus.stall_count    = stallCount;

  muldiv_tracker #(
    .MD_CYCLES (MD_CYCLES)
  ) u_tracker (
    .clk    (clk),
    .reset  (reset),
    .mdOp   (dec.mdOp),
    .stall  (stall),
    .mdGo   (mdGo),
    .mdBusy (mdBusy)
  );

  // Cause FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Cause FSM: next state is the highest-priority active cause
  always_comb begin
    stateNext = IDLE;
    if (loadUse) begin
      stateNext = S_LOAD;
    end else if (linkWait) begin
      stateNext = S_LINK;
    end else if (mdWait) begin
      stateNext = S_MD;
    end
  end

  // Cause FSM: output decode
  always_comb begin
    stallCause = CAUSE_NONE;
    unique case (state)
      S_LOAD:  stallCause = CAUSE_LOAD;
      S_LINK:  stallCause = CAUSE_LINK;
      S_MD:    stallCause = CAUSE_MD;
      default: stallCause = CAUSE_NONE;
    endcase
  end

  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
    end else if (bus.perf_clear) begin
      stallCount <= '0;
    end else if (stall && (stallCount != '1)) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: per-cycle expectations are queued as
// stimulus is applied and checked against the DUT mid-cycle.
module tb_pipe_stall_ctrl;

  localparam int unsigned MD_CYC = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_JAL  = 32'h0C00_0000;
  localparam logic [31:0] I_MULT = 32'h0000_0018;
  localparam logic [31:0] I_DIV  = 32'h0000_001A;
  localparam logic [31:0] I_MFLO = 32'h0000_0012;

  typedef struct {
    int en;
    int go;
    int busy;
    int cause;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .MD_CYCLES (MD_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setIn(input logic [31:0] instr, input int rs, input int rt,
                       input int exRt, input bit load, input bit exW,
                       input bit memW, input bit wbW, input bit clr);
    bus.id_instr      = instr;
    bus.id_rs         = 5'(rs);
    bus.id_rt         = 5'(rt);
    bus.ex_rt         = 5'(exRt);
    bus.ex_is_load    = load;
    bus.ex_reg_write  = exW;
    bus.mem_reg_write = memW;
    bus.wb_reg_write  = wbW;
    bus.perf_clear    = clr;
  endtask

  // Queue this cycle's expectation, check it mid-cycle, then advance past the edge
  task automatic step(input int en, input int go, input int busy, input int cause, input int cnt);
    exp_t e;
    expQ.push_back('{en: en, go: go, busy: busy, cause: cause, cnt: cnt});
    @(negedge clk);
    e = expQ.pop_front();
    chk("pc_enable",      int'(bus.pc_enable),      e.en);
    chk("if_enable",      int'(bus.if_enable),      e.en);
    chk("control_enable", int'(bus.control_enable), e.en);
    chk("md_go",          int'(bus.md_go),          e.go);
    chk("md_busy",        int'(bus.md_busy),        e.busy);
    chk("stall_cause",    int'(bus.stall_cause),    e.cause);
    chk("stall_count",    int'(bus.stall_count),    e.cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // Hazard and md_op present during reset must not stall or launch
    setIn(I_MULT, 5, 0, 5, 1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    reset = 1'b0;

    // Load-use: one stall cycle
    setIn(I_NOP, 5, 0, 5, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    setIn(I_NOP, 5, 0, 5, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    // Load into r0 is never a hazard
    setIn(I_NOP, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);

    // JAL waits for EX, then MEM, then WB writes to drain
    setIn(I_JAL, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    setIn(I_JAL, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 2, 2);
    setIn(I_JAL, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 2, 3);
    setIn(I_JAL, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 2, 4);
    setIn(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 4);

    // MULT launch, then MFLO stalls for the whole busy window
    setIn(I_MULT, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 4);
    setIn(I_MFLO, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 4);
    step(0, 0, 1, 3, 5);
    step(0, 0, 1, 3, 6);
    step(0, 0, 1, 3, 7);
    step(1, 0, 0, 3, 8);
    setIn(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 8);

    // DIV then MULT: second launch MD_CYC+1 cycles after the first
    setIn(I_DIV, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 8);
    setIn(I_MULT, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 8);
    step(0, 0, 1, 3, 9);
    step(0, 0, 1, 3, 10);
    step(0, 0, 1, 3, 11);
    step(1, 1, 0, 3, 12);
    setIn(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 12);

    // Load-use and link wait together: load wins; perf_clear during a stall
    setIn(I_JAL, 7, 0, 7, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 12);
    setIn(I_JAL, 7, 0, 7, 0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 13);
    setIn(I_JAL, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 2, 0);

    // Load-use on a MULT suppresses md_go until the next free cycle
    setIn(I_MULT, 0, 3, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    setIn(I_MULT, 0, 3, 3, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    setIn(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    setIn(I_MFLO, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);

    // Reset mid-multiply (counter at 2) takes effect immediately
    reset = 1'b1;
    #1;
    chk("rst_md_busy",     int'(bus.md_busy),     0);
    chk("rst_stall_cause", int'(bus.stall_cause), 0);
    chk("rst_pc_enable",   int'(bus.pc_enable),   1);
    chk("rst_md_go",       int'(bus.md_go),       0);
    chk("rst_stall_count", int'(bus.stall_count), 0);
    step(1, 0, 0, 0, 0);
    reset = 1'b0;
    setIn(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Counter saturates at all-ones
    setIn(I_NOP, 9, 0, 9, 1, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) begin
      step(0, 0, 0, (i == 0) ? 0 : 1, (i < 255) ? i : 255);
    end
    setIn(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 255);

    // New md_op after reset launches normally
    setIn(I_MULT, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 255);
    setIn(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 255);

    if (expQ.size() != 0) begin
      chk("scoreboard_drain", expQ.size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
